// File: rtl/mem_access_seq_if.sv
// Request/response and pipelined Wishbone bundle for the memory access sequencer.
// master is the sequencer side, slave is the pipeline plus memory side.
interface mem_access_seq_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [31:0] req_addr_i;
  logic        req_we_i;
  logic [31:0] req_wdata_i;
  logic [1:0]  req_size_i;
  logic        req_unsigned_i;
  logic        rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic [1:0]  rsp_err_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic        wb_stb_o;
  logic        wb_cyc_o;
  logic        wb_ack_i;
  logic        wb_stall_i;

  modport master (
    input  req_valid_i, req_addr_i, req_we_i,
    input  req_wdata_i, req_size_i, req_unsigned_i,
    input  wb_dat_i, wb_ack_i, wb_stall_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o,
    output rsp_err_o, wb_adr_o, wb_dat_o,
    output wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o
  );

  modport slave (
    output req_valid_i, req_addr_i, req_we_i,
    output req_wdata_i, req_size_i, req_unsigned_i,
    output wb_dat_i, wb_ack_i, wb_stall_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o,
    input  rsp_err_o, wb_adr_o, wb_dat_o,
    input  wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o
  );
endinterface

// File: rtl/mem_access_seq.sv
// Load/store sequencer: one pipeline request becomes one pipelined
// Wishbone transfer with alignment check, lane steering and ack timeout.
module mem_access_seq #(
  parameter int unsigned ACK_TIMEOUT = 32
) (
  input logic              clk_i,
  input logic              rst_i,
  mem_access_seq_if.master bus
);
  typedef enum logic [1:0] {
    IDLE, REQUEST, WAIT_ACK, RESPOND
  } state_t;

  localparam logic [7:0] TMO = 8'(ACK_TIMEOUT);

  state_t      state, state_nxt;
  logic [7:0]  cnt;
  logic [31:0] adr_q, dat_q, rdata_q;
  logic [31:0] dat_nxt, shifted, ext;
  logic [3:0]  sel_q, sel_nxt;
  logic [1:0]  off_q, size_q, err_q;
  logic        we_q, uns_q;
  logic        ready, accept, misal;
  logic        active, ack_take, tmo_hit;

  assign ready    = (state == IDLE) & ~rst_i;
  assign accept   = bus.req_valid_i & ready;
  assign active   = (state == REQUEST) | (state == WAIT_ACK);
  assign ack_take = bus.wb_ack_i &
                    (((state == REQUEST) & ~bus.wb_stall_i) |
                     (state == WAIT_ACK));
  assign tmo_hit  = active & ((cnt + 8'd1) == TMO);
  assign shifted  = bus.wb_dat_i >> {off_q, 3'b000};

  always_comb begin
    misal   = 1'b1;
    sel_nxt = 4'b1111;
    dat_nxt = bus.req_wdata_i;
    unique case (bus.req_size_i)
      2'b00: begin
        misal   = 1'b0;
        sel_nxt = 4'b0001 << bus.req_addr_i[1:0];
        dat_nxt = {4{bus.req_wdata_i[7:0]}};
      end
      2'b01: begin
        misal   = bus.req_addr_i[0];
        sel_nxt = 4'b0011 << bus.req_addr_i[1:0];
        dat_nxt = {2{bus.req_wdata_i[15:0]}};
      end
      2'b10: misal = |bus.req_addr_i[1:0];
      default: misal = 1'b1;
    endcase
  end

  always_comb begin
    ext = shifted;
    unique case (size_q)
      2'b00: ext = uns_q ? {24'h0, shifted[7:0]}
                         : {{24{shifted[7]}}, shifted[7:0]};
      2'b01: ext = uns_q ? {16'h0, shifted[15:0]}
                         : {{16{shifted[15]}}, shifted[15:0]};
      default: ext = shifted;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:
        if (accept) state_nxt = misal ? RESPOND : REQUEST;
      REQUEST:
        if (ack_take || tmo_hit)  state_nxt = RESPOND;
        else if (!bus.wb_stall_i) state_nxt = WAIT_ACK;
      WAIT_ACK:
        if (ack_take || tmo_hit) state_nxt = RESPOND;
      RESPOND: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Ack is checked before the timeout so a same-cycle ack still succeeds.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      off_q   <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      cnt     <= '0;
      err_q   <= '0;
      rdata_q <= '0;
    end else if (accept) begin
      adr_q   <= {bus.req_addr_i[31:2], 2'b00};
      dat_q   <= dat_nxt;
      sel_q   <= sel_nxt;
      we_q    <= bus.req_we_i;
      off_q   <= bus.req_addr_i[1:0];
      size_q  <= bus.req_size_i;
      uns_q   <= bus.req_unsigned_i;
      cnt     <= '0;
      err_q   <= misal ? 2'b01 : 2'b00;
      rdata_q <= '0;
    end else if (active) begin
      cnt <= cnt + 8'd1;
      if (ack_take) begin
        err_q   <= 2'b00;
        rdata_q <= we_q ? 32'h0 : ext;
      end else if (tmo_hit) begin
        err_q   <= 2'b10;
        rdata_q <= '0;
      end
    end
  end

  always_comb begin
    bus.req_ready_o = ready;
    bus.wb_cyc_o    = active;
    bus.wb_stb_o    = (state == REQUEST);
    bus.wb_adr_o    = adr_q;
    bus.wb_dat_o    = dat_q;
    bus.wb_we_o     = active & we_q;
    bus.wb_sel_o    = active ? sel_q : 4'b0000;
    bus.rsp_valid_o = (state == RESPOND);
    bus.rsp_rdata_o = (state == RESPOND) ? rdata_q : 32'h0;
    bus.rsp_err_o   = (state == RESPOND) ? err_q : 2'b00;
  end
endmodule

// File: tb/tb_mem_access_seq.sv
// Bench for mem_access_seq: directed cases plus random transfers
// checked against an arithmetic model of the access rules.
module tb_mem_access_seq;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mem_access_seq_if bus ();

  mem_access_seq #(.ACK_TIMEOUT(TO)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit m_misal(input logic [31:0] a, input int sz);
    if (sz == 3) return 1'b1;
    if (sz == 1) return (a % 2) != 0;
    if (sz == 2) return (a % 4) != 0;
    return 1'b0;
  endfunction

  function automatic logic [3:0] m_sel(input logic [31:0] a, input int sz);
    int off;
    off = a % 4;
    if (sz == 0) return 4'(1 << off);
    if (sz == 1) return 4'(3 << off);
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_dat(input logic [31:0] w, input int sz);
    if (sz == 0) return (w & 32'hFF) * 32'h01010101;
    if (sz == 1) return (w & 32'hFFFF) * 32'h00010001;
    return w;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] a, input int sz,
                                         input bit u, input logic [31:0] d);
    logic [31:0] v;
    v = d >> (8 * (a % 4));
    if (sz == 0) begin
      v = v & 32'hFF;
      if (!u && v >= 32'd128) v = v | 32'hFFFFFF00;
    end else if (sz == 1) begin
      v = v & 32'hFFFF;
      if (!u && v >= 32'd32768) v = v | 32'hFFFF0000;
    end
    return v;
  endfunction

  // ackdly: cycles after the accepted strobe before ack, -1 = never
  task automatic do_txn(input string tag, input logic [31:0] addr,
                        input bit we, input logic [31:0] wdata,
                        input int sz, input bit u, input int nstall,
                        input int ackdly, input logic [31:0] rdat);
    bit          mis, seen, bad;
    int          ack_c, len, estb, eerr, rsp_at, rsp_c;
    logic [31:0] erd, ex_adr, ex_dat, got_rd, got_err;
    logic [3:0]  ex_sel;
    mis    = m_misal(addr, sz);
    ex_adr = addr & 32'hFFFFFFFC;
    ex_sel = m_sel(addr, sz);
    ex_dat = m_dat(wdata, sz);
    ack_c  = (ackdly < 0) ? 1000 : nstall + 1 + ackdly;
    if (mis) begin
      len = 0; eerr = 1;
    end else if (ack_c <= TO) begin
      len = ack_c; eerr = 0;
    end else begin
      len = TO; eerr = 2;
    end
    estb   = (nstall + 1 < len) ? nstall + 1 : len;
    rsp_at = len + 1;
    erd    = (eerr != 0 || we) ? 32'h0 : m_load(addr, sz, u, rdat);

    bus.req_valid_i    = 1'b1;
    bus.req_addr_i     = addr;
    bus.req_we_i       = we;
    bus.req_wdata_i    = wdata;
    bus.req_size_i     = 2'(sz);
    bus.req_unsigned_i = u;
    bus.wb_stall_i     = 1'b0;
    bus.wb_ack_i       = 1'($urandom % 2);
    chk({tag, "_ready"}, 32'(bus.req_ready_o), 32'd1);
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    bus.req_addr_i  = $urandom;
    bus.req_wdata_i = $urandom;
    bus.req_size_i  = 2'($urandom % 4);

    seen = 1'b0; bad = 1'b0; rsp_c = 0;
    got_rd = '0; got_err = '0;
    for (int c = 1; c <= 40 && !seen; c++) begin
      if (bus.wb_cyc_o !== (c <= len)) bad = 1'b1;
      if (bus.wb_stb_o !== (c <= estb)) bad = 1'b1;
      if (c <= len) begin
        if (bus.wb_adr_o !== ex_adr) bad = 1'b1;
        if (bus.wb_sel_o !== ex_sel) bad = 1'b1;
        if (bus.wb_we_o !== we) bad = 1'b1;
        if (bus.wb_dat_o !== ex_dat) bad = 1'b1;
      end else begin
        if (bus.wb_sel_o !== 4'h0 || bus.wb_we_o !== 1'b0) bad = 1'b1;
      end
      if (bus.rsp_valid_o === 1'b1) begin
        seen    = 1'b1;
        rsp_c   = c;
        got_rd  = bus.rsp_rdata_o;
        got_err = 32'(bus.rsp_err_o);
      end
      bus.wb_stall_i = (c <= nstall);
      bus.wb_ack_i   = (c <= len) ? (c == ack_c) : 1'($urandom % 2);
      bus.wb_dat_i   = (c == ack_c) ? rdat : $urandom;
      if (!seen) @(negedge clk);
    end
    chk({tag, "_bus"}, 32'(bad), 32'd0);
    chk({tag, "_rsp_cycle"}, 32'(rsp_c), 32'(rsp_at));
    chk({tag, "_err"}, got_err, 32'(eerr));
    chk({tag, "_rdata"}, got_rd, erd);
    @(negedge clk);
    chk({tag, "_single"}, 32'(bus.rsp_valid_o), 32'd0);
    bus.wb_ack_i   = 1'b0;
    bus.wb_stall_i = 1'b0;
  endtask

  initial begin
    bit late;
    bus.req_valid_i    = 1'b0;
    bus.req_addr_i     = '0;
    bus.req_we_i       = 1'b0;
    bus.req_wdata_i    = '0;
    bus.req_size_i     = '0;
    bus.req_unsigned_i = 1'b0;
    bus.wb_dat_i       = '0;
    bus.wb_ack_i       = 1'b0;
    bus.wb_stall_i     = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(bus.req_ready_o), 32'd0);
    chk("rst_cyc", 32'(bus.wb_cyc_o), 32'd0);
    chk("rst_stb", 32'(bus.wb_stb_o), 32'd0);
    chk("rst_rsp", 32'(bus.rsp_valid_o), 32'd0);
    chk("rst_sel", 32'(bus.wb_sel_o), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    do_txn("word_ld", 32'h100, 0, 32'h0, 2, 0, 0, 2, 32'hDEADBEEF);
    do_txn("sbyte_ld", 32'h103, 0, 32'h0, 0, 0, 0, 1, 32'h80000000);
    do_txn("ubyte_ld", 32'h103, 0, 32'h0, 0, 1, 0, 0, 32'h80000000);
    do_txn("half_st", 32'h202, 1, 32'h1234ABCD, 1, 0, 3, 1, 32'h5A5A5A5A);
    do_txn("misal", 32'h101, 0, 32'h0, 2, 0, 0, 0, 32'h0);
    do_txn("res_size", 32'h104, 1, 32'h0, 3, 0, 0, 0, 32'h0);
    do_txn("timeout", 32'h400, 0, 32'h0, 2, 0, 0, -1, 32'h0);
    do_txn("ack_last", 32'h404, 0, 32'h0, 2, 0, 0, 7, 32'hCAFEF00D);
    do_txn("stall_tmo", 32'h408, 1, 32'h1, 2, 0, 10, 0, 32'h0);

    bus.req_valid_i = 1'b1;
    bus.req_addr_i  = 32'h300;
    bus.req_we_i    = 1'b0;
    bus.req_size_i  = 2'd2;
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_cyc", 32'(bus.wb_cyc_o), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_cyc", 32'(bus.wb_cyc_o), 32'd0);
    chk("mid_rst_stb", 32'(bus.wb_stb_o), 32'd0);
    chk("mid_rst_rsp", 32'(bus.rsp_valid_o), 32'd0);
    rst = 1'b0;
    bus.wb_ack_i = 1'b1;
    late = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bus.rsp_valid_o !== 1'b0 || bus.wb_cyc_o !== 1'b0) late = 1'b1;
    end
    chk("late_ack", 32'(late), 32'd0);
    bus.wb_ack_i = 1'b0;
    do_txn("post_rst", 32'h302, 0, 32'h0, 1, 0, 1, 2, 32'h8001FFFF);

    for (int i = 0; i < 40; i++) begin
      int ns, ad;
      ns = ($urandom % 5 == 0) ? int'($urandom_range(0, 10))
                               : int'($urandom % 3);
      ad = ($urandom % 6 == 0) ? -1 : int'($urandom_range(0, 8));
      do_txn($sformatf("rnd%0d", i), $urandom, 1'($urandom % 2),
             $urandom, int'($urandom % 4), 1'($urandom % 2),
             ns, ad, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_access_seq.md
MEM_ACCESS_SEQ -- requirements
Module: mem_access_seq

Interface
- REQ-001 SHALL have parameter ACK_TIMEOUT, default 32: max cycles with wb_cyc_o high before abort; legal range 2..255.
- REQ-002 clk_i  in  1  single clock; all logic on rising edge.
- REQ-003 rst_i  in  1  reset, synchronous, active-high.
- REQ-004 req_valid_i  in  1  pipeline request present.
- REQ-005 req_ready_o  out  1  sequencer accepts request.
- REQ-006 req_addr_i  in  32  byte address.
- REQ-007 req_we_i  in  1  1 = store, 0 = load.
- REQ-008 req_wdata_i  in  32  store data, LSB-aligned.
- REQ-009 req_size_i  in  2  00 byte, 01 half, 10 word; 11 reserved, treated as misaligned.
- REQ-010 req_unsigned_i  in  1  load zero-extends when 1, sign-extends when 0.
- REQ-011 rsp_valid_o  out  1  one-cycle completion pulse.
- REQ-012 rsp_rdata_o  out  32  extended load data; 0 for stores and errors.
- REQ-013 rsp_err_o  out  2  00 ok, 01 misaligned, 10 timeout.
- REQ-014 wb_adr_o out 32, wb_dat_o out 32, wb_dat_i in 32, wb_we_o out 1, wb_sel_o out 4, wb_stb_o out 1, wb_cyc_o out 1, wb_ack_i in 1, wb_stall_i in 1: pipelined Wishbone master, drives an emm slave port.

Function
- REQ-015 FSM states SHALL be IDLE, REQUEST, WAIT_ACK, RESPOND.
- REQ-016 req_ready_o SHALL be 1 only in IDLE; acceptance = req_valid_i & req_ready_o.
- REQ-017 Misaligned check on accept: half with addr[0]=1, word with addr[1:0]!=0, or size 11 -> go to RESPOND, err 01, no bus cycle.
- REQ-018 Aligned accept at cycle T SHALL go to REQUEST; wb_cyc_o and wb_stb_o high from T+1.
- REQ-019 REQUEST: wb_stb_o held while wb_stall_i=1; first cycle with wb_stall_i=0 -> WAIT_ACK, wb_stb_o low next cycle.
- REQ-020 WAIT_ACK: wb_cyc_o held high until wb_ack_i=1; ack sampled at cycle A -> RESPOND at A+1, wb_cyc_o low at A+1.
- REQ-021 wb_ack_i=1 in REQUEST with wb_stall_i=0 SHALL complete the transfer (go straight to RESPOND).
- REQ-022 wb_ack_i outside REQUEST/WAIT_ACK SHALL be ignored.
- REQ-023 RESPOND lasts exactly 1 cycle with rsp_valid_o=1, then IDLE; next accept earliest the following cycle.
- REQ-024 wb_adr_o = {addr[31:2],2'b00}; wb_we_o = req_we_i; all bus outputs registered at accept and stable for the whole cycle.
- REQ-025 wb_sel_o: byte 0001<<addr[1:0]; half 0011<<addr[1:0]; word 1111.
- REQ-026 wb_dat_o: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
- REQ-027 Load data: wb_dat_i captured on ack, shifted right by 8*addr[1:0], then byte/half zero- or sign-extended per req_unsigned_i; word unchanged.
- REQ-028 Timeout counter: 8-bit, cleared on entering REQUEST, +1 per cycle wb_cyc_o high; reaching ACK_TIMEOUT without ack -> drop cyc/stb next cycle, RESPOND with err 10.
- REQ-029 Ack in the same cycle the counter reaches ACK_TIMEOUT: ack wins, err 00.
- REQ-030 Outputs not driven by an active state SHALL be 0 (stb, cyc, we, sel, rsp_*).

Reset
- REQ-031 rst_i=1 SHALL force IDLE, counter 0, all outputs 0 except req_ready_o=0 during reset, 1 first cycle after.
- REQ-032 Reset mid-transaction SHALL drop wb_cyc_o/wb_stb_o on the next edge and emit no rsp_valid_o.

Verification
- REQ-033 Word load addr 0x100, stall 0, ack 2 cycles after stb, dat_i 0xDEADBEEF -> adr 0x100, sel 1111, rsp_valid once, rdata 0xDEADBEEF, err 00.
- REQ-034 Signed byte load addr 0x103, dat_i 0x80000000 -> sel 1000, rdata 0xFFFFFF80; unsigned -> 0x00000080.
- REQ-035 Half store addr 0x202, wdata 0x1234ABCD, stall 3 cycles -> stb held 4 cycles, sel 1100, dat_o 0xABCDABCD, we 1, rsp err 00 rdata 0.
- REQ-036 Word load addr 0x101 -> no cyc/stb ever, rsp_valid next cycle, err 01.
- REQ-037 ACK_TIMEOUT=8, no ack -> cyc high exactly 8 cycles, then rsp err 10; repeat with ack on 8th cycle -> err 00.
- REQ-038 rst_i asserted in WAIT_ACK -> cyc 0 next cycle, no rsp_valid, late ack ignored, next request completes normally.
